// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: default width, ALUop code values and op helpers.
// The ALUop values below mirror the shared ALUop.vh encoding; this block defines no new codes.
package seq_alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLT    = 4'd5;
    localparam logic [3:0] ALU_SLTU   = 4'd6;
    localparam logic [3:0] ALU_SLL    = 4'd7;
    localparam logic [3:0] ALU_SRL    = 4'd8;
    localparam logic [3:0] ALU_SRA    = 4'd9;
    localparam logic [3:0] ALU_COPY_A = 4'd10;
    localparam logic [3:0] ALU_COPY_B = 4'd11;
    localparam logic [3:0] ALU_XXX    = 4'd15;

    // True for the three shift operations.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Issue/result handshake bundle between the control unit (master) and seq_alu (slave).
interface seq_alu_if
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUop;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, ALUop, A, B, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, ALUop, A, B, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter used by seq_alu when ALU_FAST_SHIFT_EN is undefined.
// start loads A and the shift amount; last_c flags the cycle whose shift is the final one.
module alu_shift_iter
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH   = ALU_WIDTH,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               last_c,
    output logic [WIDTH-1:0]   value_c
);
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] count;
    logic [3:0]         op_q;

    // Working register advanced by one bit position; SRA replicates the sign bit.
    always_comb begin
        value_c = {1'b0, work[WIDTH-1:1]};
        if (op_q == ALU_SLL) begin
            value_c = {work[WIDTH-2:0], 1'b0};
        end else if (op_q == ALU_SRA) begin
            value_c = {work[WIDTH-1], work[WIDTH-1:1]};
        end
    end

    assign last_c = (count == SHAMT_W'(1));

    // Load on start, then shift once and count down each cycle until the count is spent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work  <= '0;
            count <= '0;
            op_q  <= ALU_SLL;
        end else if (start) begin
            work  <= a;
            count <= shamt;
            op_q  <= op;
        end else if (count != '0) begin
            work  <= value_c;
            count <= count - SHAMT_W'(1);
        end
    end
endmodule

// File: rtl/seq_alu.sv
// Sequential EX-stage ALU with valid/ready issue and result handshakes.
// Build option ALU_FAST_SHIFT_EN: single-cycle barrel shifter instead of the iterative shifter.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    seq_alu_if.slave   bus
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               accept_c;
    logic               start_iter_c;
    logic [SHAMT_W-1:0] shamt_c;
    logic [WIDTH-1:0]   alu_c;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;

    assign shamt_c  = bus.B[SHAMT_W-1:0];
    assign accept_c = bus.in_valid && bus.in_ready;

`ifdef ALU_FAST_SHIFT_EN
    assign start_iter_c = 1'b0;
`else
    logic             iter_last_c;
    logic [WIDTH-1:0] iter_value_c;

    assign start_iter_c = accept_c && is_shift(bus.ALUop) && (shamt_c != '0);

    alu_shift_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .start   (start_iter_c),
        .op      (bus.ALUop),
        .a       (bus.A),
        .shamt   (shamt_c),
        .last_c  (iter_last_c),
        .value_c (iter_value_c)
    );
`endif

    // Single-cycle result for the op being offered; zero-amount shifts pass A through.
    always_comb begin
        alu_c = '0;
        case (bus.ALUop)
            ALU_ADD:    alu_c = bus.A + bus.B;
            ALU_SUB:    alu_c = bus.A - bus.B;
            ALU_AND:    alu_c = bus.A & bus.B;
            ALU_OR:     alu_c = bus.A | bus.B;
            ALU_XOR:    alu_c = bus.A ^ bus.B;
            ALU_SLT:    alu_c = WIDTH'($signed(bus.A) < $signed(bus.B));
            ALU_SLTU:   alu_c = WIDTH'(bus.A < bus.B);
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL:    alu_c = bus.A << shamt_c;
            ALU_SRL:    alu_c = bus.A >> shamt_c;
            ALU_SRA:    alu_c = WIDTH'($signed(bus.A) >>> shamt_c);
`else
            ALU_SLL, ALU_SRL, ALU_SRA: alu_c = bus.A;
`endif
            ALU_COPY_A: alu_c = bus.A;
            ALU_COPY_B: alu_c = bus.B;
            default:    alu_c = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: accept from IDLE or a draining DONE, stay in SHIFT until the last bit.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept_c) begin
                    state_nxt = start_iter_c ? ST_SHIFT : ST_DONE;
                end else if ((state == ST_DONE) && bus.out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
`ifdef ALU_FAST_SHIFT_EN
                state_nxt = ST_IDLE;
`else
                if (iter_last_c) begin
                    state_nxt = ST_DONE;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; in_ready also opens on a draining DONE.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ST_IDLE: bus.in_ready = 1'b1;
            ST_DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
            end
            default: ;
        endcase
    end

    // Result and zero flag registered together; held until the next op completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else if (accept_c && !start_iter_c) begin
            result_q <= alu_c;
            zero_q   <= (alu_c == '0);
        end
`ifndef ALU_FAST_SHIFT_EN
        else if ((state == ST_SHIFT) && iter_last_c) begin
            result_q <= iter_value_c;
            zero_q   <= (iter_value_c == '0);
        end
`endif
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus randomized ops against a behavioural model.
module tb_seq_alu;
    import seq_alu_pkg::*;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int NOPS = 300;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    exp_t q[$];
    logic exp_valid;
    logic exp_rdy;

    seq_alu_if #(.WIDTH(32)) bus ();

    seq_alu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result from the op definitions.
    function automatic logic [31:0] golden(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_AND:    return a & b;
            ALU_OR:     return a | b;
            ALU_XOR:    return a ^ b;
            ALU_SLT:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:    return a << sh;
            ALU_SRL:    return a >> sh;
            ALU_SRA:    return 32'($signed(a) >>> sh);
            ALU_COPY_A: return a;
            ALU_COPY_B: return b;
            default:    return 32'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] op, input logic [31:0] b);
        if (!FAST && is_shift(op) && (b[4:0] != 5'd0)) return int'(b[4:0]) + 1;
        return 1;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Per-cycle compare of handshake and result against the model queue.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_in_ready", 32'(bus.in_ready), 32'd1);
            check("rst_result", bus.result, 32'd0);
            check("rst_zero", 32'(bus.zero), 32'd1);
        end else begin
            exp_valid = (q.size() > 0) && (cyc >= q[0].due);
            check("mon_out_valid", 32'(bus.out_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("mon_result", bus.result, q[0].res);
                check("mon_zero", 32'(bus.zero), 32'(q[0].res == 32'd0));
                exp_rdy = bus.out_ready;
            end else begin
                exp_rdy = (q.size() == 0);
            end
            check("mon_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            if (exp_valid && bus.out_ready) q.pop_front();
            if (bus.in_valid && bus.in_ready) begin
                q.push_back('{res: golden(bus.ALUop, bus.A, bus.B),
                              due: cyc + lat_of(bus.ALUop, bus.B)});
            end
        end
    end

    // One op with out_ready high; checks result, zero and accept-to-valid latency against literals.
    task automatic directed(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z,
                            input int exp_lat);
        int acc;
        int n;
        @(posedge clk); #1;
        bus.ALUop = op; bus.A = a; bus.B = b;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 64) begin @(negedge clk); n++; end
        acc = cyc;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!bus.out_valid && n < 64) begin @(negedge clk); n++; end
        check({name, "_result"}, bus.result, exp_r);
        check({name, "_zero"}, 32'(bus.zero), 32'(exp_z));
        check({name, "_latency"}, 32'(cyc - acc), 32'(exp_lat));
    endtask

    initial begin
        int  issued;
        int  guard;
        int  n;
        logic took;
        cyc = 0; total = 0; bad = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.ALUop = 4'd0; bus.A = 32'd0; bus.B = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_result", bus.result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        directed("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1);
        directed("sub_eq", ALU_SUB, 32'h1234, 32'h1234, 32'h0, 1'b1, 1);
        directed("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
        directed("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1);
        directed("sra4", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, FAST ? 1 : 5);
        directed("sll_sh0", ALU_SLL, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1'b0, 1);
        directed("sll31", ALU_SLL, 32'd1, 32'd31, 32'h8000_0000, 1'b0, FAST ? 1 : 32);
        directed("srl31", ALU_SRL, 32'hFFFF_FFFF, 32'd31, 32'd1, 1'b0, FAST ? 1 : 32);
        directed("xxx", ALU_XXX, 32'h55, 32'hAA, 32'h0, 1'b1, 1);
        directed("copy_b", ALU_COPY_B, 32'h55, 32'hAA, 32'hAA, 1'b0, 1);

        // Backpressure: result held while out_ready is low, then same-cycle accept on release.
        @(posedge clk); #1;
        bus.ALUop = ALU_OR; bus.A = 32'hF0; bus.B = 32'h0F;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_result", bus.result, 32'hFF);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            @(posedge clk); #1;
        end
        bus.ALUop = ALU_XOR; bus.A = 32'hFF; bus.B = 32'h0F;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid", 32'(bus.out_valid), 32'd1);
        check("bp_next_result", bus.result, 32'hF0);

        // Reset during the third shift cycle of SRL by 8.
        @(posedge clk); #1;
        bus.ALUop = ALU_SRL; bus.A = 32'hFFFF_0000; bus.B = 32'd8;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_result", bus.result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        directed("after_rst", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1);

        // Randomized ops with random issue gaps and out_ready stalls.
        issued = 0; guard = 0;
        bus.in_valid = 1'b0;
        while (issued < NOPS && guard < 60000) begin
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            guard++;
            if (took) issued++;
            if (!bus.in_valid || took) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus.in_valid = 1'b1;
                    bus.ALUop = 4'($urandom_range(0, 15));
                    bus.A = rand_word();
                    bus.B = rand_word();
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        check("rand_progress", 32'(issued), 32'(NOPS));

        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
